// File: rtl/nandy_pkg.sv
// Shared package: state encoding for the bit-serial adder.
package nandy_pkg;

  typedef enum logic [1:0] {
    SERIAL_ADDER_IDLE  = 2'd0,
    SERIAL_ADDER_SHIFT = 2'd1,
    SERIAL_ADDER_DONE  = 2'd2
  } serial_adder_state_t;

endpackage : nandy_pkg

// File: rtl/serial_adder_fulladder.sv
// Fulladder: single-bit full-adder cell used for the per-bit add.
module Fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Pure combinational sum/carry of one bit position.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule : Fulladder

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder built around one Fulladder cell.
// One operand bit pair is added per clock with the carry held in a flop;
// the result is shifted into the sum register from the MSB end.
// Optional macro SERIAL_ADDER_OVERFLOW_EN adds a signed-overflow output.
module serial_adder
  import nandy_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inCarry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serial_adder_state_t state_q, state_d;
  logic [WIDTH-1:0]    opa_q, opa_d;
  logic [WIDTH-1:0]    opb_q, opb_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    count_q, count_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic                msb_cin_q, msb_cin_d;
`endif

  logic fa_s;
  logic fa_c;

  Fulladder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Next-state and datapath update: load on an accepted start, shift in SHIFT.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    count_d = count_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    msb_cin_d = msb_cin_q;
`endif

    case (state_q)
      SERIAL_ADDER_IDLE, SERIAL_ADDER_DONE: begin
        if (start) begin
          opa_d   = inA;
          opb_d   = inB;
          carry_d = inCarry;
          count_d = '0;
          state_d = SERIAL_ADDER_SHIFT;
        end else begin
          state_d = SERIAL_ADDER_IDLE;
        end
      end

      SERIAL_ADDER_SHIFT: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        carry_d = fa_c;
        if (count_q == LAST_BIT) begin
          // Terminal bit: hold the counter rather than let it wrap.
`ifdef SERIAL_ADDER_OVERFLOW_EN
          msb_cin_d = carry_q;
`endif
          state_d = SERIAL_ADDER_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

      default: state_d = SERIAL_ADDER_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= SERIAL_ADDER_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      msb_cin_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      msb_cin_q <= msb_cin_d;
`endif
    end
  end

  // Outputs are registers or pure decodes of the state register.
  always_comb begin
    busy  = (state_q == SERIAL_ADDER_SHIFT);
    done  = (state_q == SERIAL_ADDER_DONE);
    sum   = sum_q;
    carry = carry_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    overflow = msb_cin_q ^ carry_q;
`endif
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             inCarry;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             overflow;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .inA     (inA),
    .inB     (inB),
    .inCarry (inCarry),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .carry   (carry)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one addition, count busy cycles, then check the DONE-cycle outputs.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [7:0] exp_sum, input logic exp_c,
                         input logic exp_ovf);
    int busy_cycles;
    int guard;
    inA = a; inB = b; inCarry = ci; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cycles = 0;
    guard = 0;
    while (busy && guard < 40) begin
      busy_cycles++;
      guard++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd8);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_carry"}, 32'(carry), 32'(exp_c));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unreachable");
`endif
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sum_held"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    int last_done;
    int cyc;
    int pulses;
    reset = 1'b1; start = 1'b0; inA = '0; inB = '0; inCarry = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    reset = 1'b0;
    tick();

    run_add("v35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_add("vff_01", 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
    run_add("v7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_add("v80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_add("vff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Idle hold: result stays put with no start.
    tick(); tick(); tick();
    check("idle_hold_sum", 32'(sum), 32'hFF);
    check("idle_hold_carry", 32'(carry), 32'd1);

    // Start re-pulsed during SHIFT with other operands must be ignored.
    inA = 8'h12; inB = 8'h34; inCarry = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    inA = 8'hAA; inB = 8'h55; inCarry = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin cyc++; tick(); end
    check("ign_wait", 32'(cyc), 32'd5);
    check("ign_sum", 32'(sum), 32'h46);
    check("ign_carry", 32'(carry), 32'd0);
    tick();
    check("ign_no_requeue", 32'(busy), 32'd0);

    // Reset in the middle of an operation discards it.
    inA = 8'hC3; inB = 8'h3C; inCarry = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_carry", 32'(carry), 32'd0);
    tick();
    check("mid_rst_idle", 32'(busy), 32'd0);
    run_add("v10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // Start held high: a result every WIDTH+1 cycles.
    inA = 8'h01; inB = 8'h01; inCarry = 1'b0; start = 1'b1;
    last_done = -1;
    pulses = 0;
    cyc = 0;
    while (pulses < 3 && cyc < 100) begin
      tick();
      cyc++;
      if (done) begin
        check("b2b_sum", 32'(sum), 32'h02);
        if (last_done >= 0) check("b2b_period", 32'(cyc - last_done), 32'd9);
        else check("b2b_first", 32'(cyc), 32'd9);
        last_done = cyc;
        pulses++;
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd3);
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
